// File: rtl/peak_dpu_if_align.sv
// Fetch-to-decode instruction aligner: buffers fetch words as halfwords and
// presents one complete 16- or 32-bit instruction per handshake with its PC.
module peak_dpu_if_align #(
    parameter int unsigned DEPTH_HW = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    input  logic        fetch_vld,
    output logic        fetch_rdy,
    input  logic [31:0] fetch_data,
    output logic        instr_vld,
    input  logic        instr_rdy,
    output logic [31:0] instr_op,
    output logic        instr_is_compressed,
    output logic [31:0] instr_pc
);

    localparam int unsigned PTR_W = $clog2(DEPTH_HW);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [15:0]      mem [DEPTH_HW];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             skip;
    logic [31:0]      pc;

    logic [15:0] h0;
    logic [15:0] h1;
    logic        compressed;
    logic        push;
    logic        pop;
    logic [1:0]  push_n;
    logic [1:0]  pop_n;

    // Head halfwords; an empty buffer reads as zero so outputs are clean after reset.
    assign h0         = (count != '0) ? mem[rd_ptr] : 16'h0000;
    assign h1         = mem[rd_ptr + PTR_W'(1)];
    assign compressed = (h0[1:0] != 2'b11);

    assign instr_vld           = ((count >= CNT_W'(1)) && compressed) || (count >= CNT_W'(2));
    assign instr_op            = compressed ? {16'h0000, h0} : {h1, h0};
    assign instr_is_compressed = compressed & instr_vld;
    assign instr_pc            = pc;
    assign fetch_rdy           = (count <= CNT_W'(DEPTH_HW - 2));

    // A flush cycle swallows both handshakes.
    assign push   = fetch_vld & fetch_rdy & ~flush;
    assign pop    = instr_vld & instr_rdy & ~flush;
    assign push_n = push ? (skip ? 2'd1 : 2'd2) : 2'd0;
    assign pop_n  = pop ? (compressed ? 2'd1 : 2'd2) : 2'd0;

    // Halfword storage; after a misaligned redirect only the upper half is kept.
    always_ff @(posedge clk) begin
        if (push) begin
            if (skip) begin
                mem[wr_ptr] <= fetch_data[31:16];
            end else begin
                mem[wr_ptr]              <= fetch_data[15:0];
                mem[wr_ptr + PTR_W'(1)]  <= fetch_data[31:16];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            skip   <= 1'b0;
            pc     <= RESET_PC;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            skip   <= flush_pc[1];
            pc     <= flush_pc & ~32'h0000_0001;
        end else begin
            rd_ptr <= rd_ptr + PTR_W'(pop_n);
            wr_ptr <= wr_ptr + PTR_W'(push_n);
            count  <= count + CNT_W'(push_n) - CNT_W'(pop_n);
            pc     <= pc + 32'({pop_n, 1'b0});
            if (push) begin
                skip <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_peak_dpu_if_align.sv
// Bench for peak_dpu_if_align: halfword-queue reference model checked every
// cycle, plus directed scenarios with literal expectations on the accepted stream.
module tb_peak_dpu_if_align;

    localparam int unsigned D   = 4;
    localparam logic [31:0] RPC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [31:0] flush_pc;
    logic        fetch_vld;
    logic        fetch_rdy;
    logic [31:0] fetch_data;
    logic        instr_vld;
    logic        instr_rdy;
    logic [31:0] instr_op;
    logic        instr_is_compressed;
    logic [31:0] instr_pc;

    peak_dpu_if_align #(.DEPTH_HW(D), .RESET_PC(RPC)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .flush               (flush),
        .flush_pc            (flush_pc),
        .fetch_vld           (fetch_vld),
        .fetch_rdy           (fetch_rdy),
        .fetch_data          (fetch_data),
        .instr_vld           (instr_vld),
        .instr_rdy           (instr_rdy),
        .instr_op            (instr_op),
        .instr_is_compressed (instr_is_compressed),
        .instr_pc            (instr_pc)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the buffered instruction stream as a plain halfword queue.
    logic [15:0] mq[$];
    logic        m_skip = 1'b0;
    logic [31:0] m_pc   = RPC;

    function automatic logic m_comp();
        return (mq.size() > 0) && (mq[0][1:0] != 2'b11);
    endfunction

    function automatic logic m_vld();
        return ((mq.size() >= 1) && m_comp()) || (mq.size() >= 2);
    endfunction

    function automatic logic [31:0] m_op();
        if (m_comp()) return {16'h0000, mq[0]};
        if (mq.size() >= 2) return {mq[1], mq[0]};
        return 32'h0;
    endfunction

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                mq.delete();
                m_skip = 1'b0;
                m_pc   = RPC;
            end else if (flush) begin
                mq.delete();
                m_skip = flush_pc[1];
                m_pc   = {flush_pc[31:1], 1'b0};
            end else begin
                int  pn;
                bit  do_pop;
                bit  do_push;
                do_pop  = m_vld() && instr_rdy;
                pn      = m_comp() ? 1 : 2;
                do_push = fetch_vld && (mq.size() <= int'(D) - 2);
                if (do_pop) begin
                    repeat (pn) void'(mq.pop_front());
                    m_pc = m_pc + 32'(2 * pn);
                end
                if (do_push) begin
                    if (m_skip) begin
                        mq.push_back(fetch_data[31:16]);
                        m_skip = 1'b0;
                    end else begin
                        mq.push_back(fetch_data[15:0]);
                        mq.push_back(fetch_data[31:16]);
                    end
                end
            end
        end
    end

    typedef struct {
        logic [31:0] op;
        logic [31:0] pc;
        logic        c;
    } ent_t;
    ent_t log_q[$];

    // Per-cycle compare against the model, and log of instructions the decoder takes.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                check1("fetch_rdy", fetch_rdy, mq.size() <= int'(D) - 2);
                check1("instr_vld", instr_vld, m_vld());
                check1("instr_is_compressed", instr_is_compressed, m_vld() && m_comp());
                check32("instr_pc", instr_pc, m_pc);
                if (m_vld()) check32("instr_op", instr_op, m_op());
                if (!flush && instr_vld && instr_rdy) begin
                    ent_t e;
                    e.op = instr_op;
                    e.pc = instr_pc;
                    e.c  = instr_is_compressed;
                    log_q.push_back(e);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst = 1'b1;
        flush = 1'b0;
        fetch_vld = 1'b0;
        instr_rdy = 1'b0;
        @(posedge clk);
        #2 rst = 1'b0;
        log_q.delete();
    endtask

    task automatic push(input logic [31:0] w);
        int k;
        fetch_vld  = 1'b1;
        fetch_data = w;
        k = 0;
        @(negedge clk);
        while (!fetch_rdy && k < 50) begin
            k++;
            @(negedge clk);
        end
        if (!fetch_rdy) check1("push_timeout", fetch_rdy, 1'b1);
        @(posedge clk);
        #2 fetch_vld = 1'b0;
    endtask

    task automatic check_ent(input string name, input int idx, input logic [31:0] op,
                             input logic [31:0] pc, input logic c);
        if (idx < log_q.size()) begin
            check32({name, "_op"}, log_q[idx].op, op);
            check32({name, "_pc"}, log_q[idx].pc, pc);
            check1({name, "_c"}, log_q[idx].c, c);
        end else begin
            check32({name, "_missing"}, 32'(log_q.size()), 32'(idx + 1));
        end
    endtask

    function automatic logic [15:0] cw(input int k, input int j);
        return 16'h4001 | 16'(k << 4) | 16'(j << 2);
    endfunction

    logic [31:0] words [10];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; flush_pc = 32'h0;
        fetch_vld = 1'b0; fetch_data = 32'h0; instr_rdy = 1'b0;
        idle(2);
        rst = 1'b0;
        @(negedge clk);
        check1("rst_vld", instr_vld, 1'b0);
        check32("rst_op", instr_op, 32'h0);
        check1("rst_comp", instr_is_compressed, 1'b0);
        check1("rst_fetch_rdy", fetch_rdy, 1'b1);
        check32("rst_pc", instr_pc, RPC);

        // Two compressed then one 32-bit instruction
        do_reset();
        instr_rdy = 1'b1;
        push(32'h4501_4581);
        push(32'h0000_0013);
        idle(6);
        check32("basic_n", 32'(log_q.size()), 32'd3);
        check_ent("basic0", 0, 32'h0000_4581, 32'h0, 1'b1);
        check_ent("basic1", 1, 32'h0000_4501, 32'h2, 1'b1);
        check_ent("basic2", 2, 32'h0000_0013, 32'h4, 1'b0);

        // 32-bit instruction waiting for its upper half across a fetch stall
        do_reset();
        instr_rdy = 1'b1;
        push(32'h0093_4505);
        repeat (3) @(negedge clk);
        check1("straddle_wait_vld", instr_vld, 1'b0);
        @(posedge clk);
        #2;
        push(32'hABCD_0000);
        idle(4);
        check_ent("strad0", 0, 32'h0000_4505, 32'h0, 1'b1);
        check_ent("strad1", 1, 32'h0000_0093, 32'h2, 1'b0);
        check_ent("strad2", 2, 32'h0000_ABCD, 32'h6, 1'b1);

        // Misaligned redirect drops the low halfword
        do_reset();
        instr_rdy = 1'b1;
        flush = 1'b1;
        flush_pc = 32'h0000_0102;
        @(posedge clk);
        #2 flush = 1'b0;
        push(32'h0001_4581);
        idle(3);
        check32("flush_n", 32'(log_q.size()), 32'd1);
        check_ent("flush0", 0, 32'h0000_0001, 32'h0000_0102, 1'b1);

        // Decoder stall until full, then drain over 10 words with wrap straddles
        do_reset();
        words[0] = {cw(0, 1), cw(0, 0)};
        for (int k = 1; k <= 8; k++)
            words[k] = (k % 2 == 1) ? {16'h0013, cw(k, 0)} : {cw(k, 0), 16'h00AB};
        words[9] = {cw(9, 1), cw(9, 0)};
        push(words[0]);
        push(words[1]);
        fetch_vld  = 1'b1;
        fetch_data = words[2];
        repeat (4) begin
            @(negedge clk);
            check1("full_fetch_rdy", fetch_rdy, 1'b0);
            check32("stall_op", instr_op, {16'h0000, cw(0, 0)});
            check32("stall_pc", instr_pc, 32'h0);
        end
        @(posedge clk);
        #2 instr_rdy = 1'b1;
        for (int k = 2; k < 10; k++) push(words[k]);
        idle(12);
        check32("drain_n", 32'(log_q.size()), 32'd16);
        check_ent("drain2", 2, {16'h0000, cw(1, 0)}, 32'd4, 1'b1);
        check_ent("drain3", 3, 32'h00AB_0013, 32'd6, 1'b0);
        check_ent("drain4", 4, {16'h0000, cw(2, 0)}, 32'd10, 1'b1);
        begin
            int hw;
            hw = 0;
            foreach (log_q[i]) hw += log_q[i].c ? 1 : 2;
            check32("drain_halfwords", 32'(hw), 32'd20);
        end

        // Flush in the same cycle as a push and a pop
        do_reset();
        instr_rdy = 1'b1;
        push(32'h4005_4001);
        flush      = 1'b1;
        flush_pc   = 32'h0000_0201;
        fetch_vld  = 1'b1;
        fetch_data = 32'h4009_400D;
        @(posedge clk);
        #2 flush = 1'b0;
        fetch_vld = 1'b0;
        @(negedge clk);
        check1("fl_same_vld", instr_vld, 1'b0);
        check32("fl_same_pc", instr_pc, 32'h0000_0200);
        check1("fl_same_rdy", fetch_rdy, 1'b1);
        @(posedge clk);
        #2;
        push(32'h4011_4015);
        idle(3);
        check32("fl_same_n", 32'(log_q.size()), 32'd2);
        check_ent("fl_same0", 0, 32'h0000_4015, 32'h0000_0200, 1'b1);
        check_ent("fl_same1", 1, 32'h0000_4011, 32'h0000_0202, 1'b1);

        // Asynchronous reset with three halfwords buffered
        do_reset();
        flush = 1'b1;
        flush_pc = 32'h0000_0012;
        @(posedge clk);
        #2 flush = 1'b0;
        push(32'hAAAA_4001);
        push(32'h4005_4009);
        @(negedge clk);
        check32("pre_rst_op", instr_op, 32'h0000_AAAA);
        check1("pre_rst_rdy", fetch_rdy, 1'b0);
        #1 rst = 1'b1;
        #1;
        check1("async_rst_vld", instr_vld, 1'b0);
        check32("async_rst_op", instr_op, 32'h0);
        check1("async_rst_comp", instr_is_compressed, 1'b0);
        check32("async_rst_pc", instr_pc, RPC);
        check1("async_rst_rdy", fetch_rdy, 1'b1);
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check1("post_rst_rdy", fetch_rdy, 1'b1);
        check1("post_rst_vld", instr_vld, 1'b0);
        check32("post_rst_pc", instr_pc, RPC);

        idle(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
